// File: rtl/maxpool_relu_1.sv
// ReLU followed by 2x2 stride-2 max-pooling over three channels of a raster conv stream.
// A half-width partial-max line buffer per channel holds the even-row pair maxima.
module maxpool_relu_1 #(
  parameter int CONV_WIDTH  = 24,
  parameter int CONV_HEIGHT = 24,
  parameter int DATA_BITS   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] conv_out_1,
  input  logic [DATA_BITS-1:0] conv_out_2,
  input  logic [DATA_BITS-1:0] conv_out_3,
  output logic [DATA_BITS-1:0] max_value_1,
  output logic [DATA_BITS-1:0] max_value_2,
  output logic [DATA_BITS-1:0] max_value_3,
  output logic                 valid_out_relu,
  output logic                 frame_done
);

  localparam int HALF_W   = CONV_WIDTH / 2;
  localparam int COL_BITS = $clog2(CONV_WIDTH);
  localparam int ROW_BITS = $clog2(CONV_HEIGHT);
  localparam int IDX_BITS = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [COL_BITS-1:0]  col;
  logic [ROW_BITS-1:0]  row;
  logic [IDX_BITS-1:0]  buf_idx;
  logic                 odd_col, odd_row, last_col, last_row;

  logic [DATA_BITS-1:0] conv_in  [3];
  logic [DATA_BITS-1:0] relu_val [3];
  logic [DATA_BITS-1:0] hold     [3];
  logic [DATA_BITS-1:0] pair     [3];
  logic [DATA_BITS-1:0] line_rd  [3];
  logic [DATA_BITS-1:0] pooled   [3];
  logic [DATA_BITS-1:0] max_q    [3];
  logic [DATA_BITS-1:0] line_buf [3][HALF_W];

  assign conv_in[0] = conv_out_1;
  assign conv_in[1] = conv_out_2;
  assign conv_in[2] = conv_out_3;

  assign max_value_1 = max_q[0];
  assign max_value_2 = max_q[1];
  assign max_value_3 = max_q[2];

  assign odd_col  = col[0];
  assign odd_row  = row[0];
  assign last_col = (col == COL_BITS'(CONV_WIDTH - 1));
  assign last_row = (row == ROW_BITS'(CONV_HEIGHT - 1));
  assign buf_idx  = IDX_BITS'(col >> 1);

  // After ReLU every value is non-negative, so the maxima can use unsigned compares.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      relu_val[ch] = conv_in[ch][DATA_BITS-1] ? '0 : conv_in[ch];
      pair[ch]     = (hold[ch] > relu_val[ch]) ? hold[ch] : relu_val[ch];
      line_rd[ch]  = line_buf[ch][buf_idx];
      pooled[ch]   = (line_rd[ch] > pair[ch]) ? line_rd[ch] : pair[ch];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 3; ch++) begin
        hold[ch]  <= '0;
        max_q[ch] <= '0;
      end
      valid_out_relu <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      valid_out_relu <= 1'b0;
      frame_done     <= 1'b0;
      if (valid_in) begin
        for (int ch = 0; ch < 3; ch++) begin
          if (!odd_col)
            hold[ch] <= relu_val[ch];
          else if (odd_row)
            max_q[ch] <= pooled[ch];
        end
        valid_out_relu <= odd_col && odd_row;
        frame_done     <= odd_col && odd_row && last_col && last_row;
      end
    end
  end

  // Written only in even rows and read only in odd rows, so contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && valid_in && odd_col && !odd_row) begin
      for (int ch = 0; ch < 3; ch++)
        line_buf[ch][buf_idx] <= pair[ch];
    end
  end

endmodule

// File: tb/tb_maxpool_relu_1.sv
// Self-checking bench for maxpool_relu_1: directed frames with a window-max reference model.
module tb_maxpool_relu_1;

  localparam int W  = 24;
  localparam int H  = 24;
  localparam int DB = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DB-1:0] conv_out_1, conv_out_2, conv_out_3;
  logic [DB-1:0] max_value_1, max_value_2, max_value_3;
  logic          valid_out_relu;
  logic          frame_done;

  always #5 clk = ~clk;

  maxpool_relu_1 #(.CONV_WIDTH(W), .CONV_HEIGHT(H), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .conv_out_1(conv_out_1), .conv_out_2(conv_out_2), .conv_out_3(conv_out_3),
    .max_value_1(max_value_1), .max_value_2(max_value_2), .max_value_3(max_value_3),
    .valid_out_relu(valid_out_relu), .frame_done(frame_done)
  );

  int vectors     = 0;
  int miscompares = 0;

  int            m_row, m_col;
  int            relu_pix [3][H][W];
  logic [DB-1:0] fr [3][H][W];
  logic [DB-1:0] exp_val [3];
  logic          exp_valid, exp_fd;
  int            pulse_cnt, fd_cnt;

  function automatic int relu(logic [DB-1:0] x);
    return x[DB-1] ? 0 : int'(x);
  endfunction

  task automatic cmp(string tag, logic [DB-1:0] obs, logic [DB-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%03h expected=0x%03h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("valid_out_relu", DB'(valid_out_relu), DB'(exp_valid));
    cmp("frame_done", DB'(frame_done), DB'(exp_fd));
    cmp("max_value_1", max_value_1, exp_val[0]);
    cmp("max_value_2", max_value_2, exp_val[1]);
    cmp("max_value_3", max_value_3, exp_val[2]);
    if (valid_out_relu === 1'b1) pulse_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  // Drive one cycle (called at a falling edge), then update the model and check after the edge.
  task automatic applyStimulus(logic r, logic v, logic [DB-1:0] a, logic [DB-1:0] b, logic [DB-1:0] c);
    logic [DB-1:0] px [3];
    int mx;
    px[0] = a; px[1] = b; px[2] = c;
    rst = r; valid_in = v; conv_out_1 = a; conv_out_2 = b; conv_out_3 = c;
    @(negedge clk);
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    if (r) begin
      m_row = 0; m_col = 0;
      for (int ch = 0; ch < 3; ch++) exp_val[ch] = '0;
    end else if (v) begin
      for (int ch = 0; ch < 3; ch++) relu_pix[ch][m_row][m_col] = relu(px[ch]);
      if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
        exp_valid = 1'b1;
        exp_fd    = (m_row == H - 1) && (m_col == W - 1);
        for (int ch = 0; ch < 3; ch++) begin
          mx = 0;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              if (relu_pix[ch][m_row-1+dr][m_col-1+dc] > mx)
                mx = relu_pix[ch][m_row-1+dr][m_col-1+dc];
          exp_val[ch] = DB'(mx);
        end
      end
      m_col++;
      if (m_col == W) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end
    end
    checkOutput();
  endtask

  task automatic sendPixels(int n_pix, bit gaps);
    int r, c;
    for (int idx = 0; idx < n_pix; idx++) begin
      r = idx / W;
      c = idx % W;
      applyStimulus(1'b0, 1'b1, fr[0][r][c], fr[1][r][c], fr[2][r][c]);
      if (gaps) begin
        repeat ($urandom_range(1, 3))
          applyStimulus(1'b0, 1'b0, DB'($urandom), DB'($urandom), DB'($urandom));
      end
    end
  endtask

  task automatic runFrame(string name, bit gaps);
    $display("[TB] frame: %s", name);
    pulse_cnt = 0;
    fd_cnt    = 0;
    sendPixels(W * H, gaps);
    cmp({name, " pulse count"}, DB'(pulse_cnt), DB'((W / 2) * (H / 2)));
    cmp({name, " frame_done count"}, DB'(fd_cnt), DB'(1));
  endtask

  task automatic fillConst(logic [DB-1:0] v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int ch = 0; ch < 3; ch++) fr[ch][r][c] = v;
  endtask

  task automatic fillRamp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        fr[0][r][c] = DB'((r * W + c) % 2048);
        fr[1][r][c] = DB'($urandom);
        fr[2][r][c] = DB'($urandom);
      end
  endtask

  // One corner per window carries the largest channel-1 value; the corner rotates per window.
  task automatic fillCorner();
    int k;
    for (int i = 0; i < H / 2; i++)
      for (int j = 0; j < W / 2; j++) begin
        k = (i * (W / 2) + j) % 4;
        for (int q = 0; q < 4; q++) begin
          fr[0][2*i+q/2][2*j+q%2] = (q == k) ? DB'($urandom_range(300, 2047))
                                             : DB'($urandom_range(0, 299));
        end
      end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        fr[1][r][c] = -fr[0][r][c];
        fr[2][r][c] = 12'h7FF;
      end
  endtask

  task automatic fillRandom();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int ch = 0; ch < 3; ch++) fr[ch][r][c] = DB'($urandom);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0;
    conv_out_1 = '0; conv_out_2 = '0; conv_out_3 = '0;
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);

    fillConst(12'h005);
    runFrame("const_005", 1'b0);

    fillConst(12'hF80);
    runFrame("all_negative", 1'b0);

    fillRamp();
    runFrame("ramp", 1'b0);

    fillCorner();
    runFrame("corner_max", 1'b0);

    fillRamp();
    runFrame("ramp_with_gaps", 1'b1);

    fillRandom();
    sendPixels(300, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    fillRandom();
    runFrame("after_reset", 1'b0);

    fillRandom();
    runFrame("random_gaps", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
